// File: rtl/snow64_memory_bus_guard.sv
// Owner of the external memory bus, shared by the read and write FIFOs.
// Round-robin grant, one line-sized transaction at a time, with a watchdog that flags a sticky error.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction outstanding, arbitrating rd_req / wr_req
// WAIT_RD | read command on the bus, waiting for mem_ack or watchdog
// WAIT_WR | write command on the bus, waiting for mem_ack or watchdog
module snow64_memory_bus_guard #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_cmd_accepted,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,

   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_cmd_accepted,
   output logic                  wr_valid,

   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,

   output logic                  busy,
   output logic                  timeout_err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_RD = 2'd1;
   localparam logic [1:0] WAIT_WR = 2'd2;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_W;

   // Counter is kept at least one bit wide so a disabled watchdog still elaborates.
   localparam int CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit WDOG_EN  = (TIMEOUT_CYCLES != 0);
   localparam int LAST_INT = WDOG_EN ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = LAST_INT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             last_grant;
   logic [CNT_W-1:0] wdog_cnt;

   logic             grant_rd;
   logic             grant_wr;
   logic             done_ok;
   logic             expire;
   logic             finish;
   logic [ADDR_WIDTH-1:0] grant_addr;

   always_comb begin
      state_next = state;
      grant_rd   = 1'b0;
      grant_wr   = 1'b0;
      done_ok    = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req && (!wr_req || (last_grant == GRANT_WR))) begin
               grant_rd   = 1'b1;
               state_next = WAIT_RD;
            end else if (wr_req) begin
               grant_wr   = 1'b1;
               state_next = WAIT_WR;
            end
         end
         WAIT_RD, WAIT_WR: begin
            // An ack on the expiry edge wins over the watchdog.
            if (mem_ack) begin
               done_ok = 1'b1;
            end else if (WDOG_EN && (wdog_cnt == CNT_LAST)) begin
               expire = 1'b1;
            end
            if (done_ok || expire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign finish     = done_ok || expire;
   assign grant_addr = (grant_wr ? wr_addr : rd_addr) & LINE_MASK;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_WR;
         wdog_cnt   <= '0;
      end else begin
         state <= state_next;
         if (grant_rd || grant_wr) begin
            wdog_cnt   <= '0;
            last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
         end else if (busy && !finish && (wdog_cnt != CNT_MAX)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (grant_rd || grant_wr) begin
            mem_req  <= 1'b1;
            mem_we   <= grant_wr;
            mem_addr <= grant_addr;
            if (grant_wr) begin
               mem_wdata <= wr_data;
            end
         end else if (finish) begin
            mem_req <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cmd_accepted <= 1'b0;
         wr_cmd_accepted <= 1'b0;
         rd_valid        <= 1'b0;
         wr_valid        <= 1'b0;
      end else begin
         rd_cmd_accepted <= grant_rd;
         wr_cmd_accepted <= grant_wr;
         rd_valid        <= finish && (state == WAIT_RD);
         wr_valid        <= finish && (state == WAIT_WR);
      end
   end

   // Aborted reads return an all-zero line so stale data is never mistaken for a result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == WAIT_RD) begin
            if (done_ok) begin
               rd_data <= mem_rdata;
            end else if (expire) begin
               rd_data <= '0;
            end
         end
         if (expire) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_snow64_memory_bus_guard.sv
// Bench for snow64_memory_bus_guard: vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_snow64_memory_bus_guard;

   localparam int AW = 64;
   localparam int DW = 256;
   localparam int TO = 8;
   localparam int LINE_BYTES = DW / 8;

   localparam logic [DW-1:0] ZW   = '0;
   localparam logic [DW-1:0] A5   = {32{8'hA5}};
   localparam logic [DW-1:0] DB   = 256'hDEADBEEF;
   localparam logic [DW-1:0] JUNK = 256'hFFFF;
   localparam logic [DW-1:0] RX   = 256'h5A5A_1234_5A5A;
   localparam logic [DW-1:0] R7   = 256'h77;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_cmd_accepted;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_cmd_accepted;
   logic          wr_valid;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;
   logic          timeout_err;

   snow64_memory_bus_guard #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_cmd_accepted(rd_cmd_accepted),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_cmd_accepted(wr_cmd_accepted), .wr_valid(wr_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic          rq;
      logic          wq;
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          ack;
      logic [DW-1:0] rdat;
      logic          e_racc;
      logic          e_wacc;
      logic          e_rval;
      logic          e_wval;
      logic          e_req;
      logic          e_we;
      logic          e_busy;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs [0:12];

   // Reference model: one outstanding transaction, its age in cycles since grant.
   bit            m_out, m_side, m_last, m_err;
   int            m_age;
   bit            m_racc, m_wacc, m_rval, m_wval, m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   task automatic model_reset();
      m_out = 0; m_side = 0; m_last = 1; m_err = 0; m_age = 0;
      m_racc = 0; m_wacc = 0; m_rval = 0; m_wval = 0; m_req = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
   endtask

   task automatic model_edge(input logic rq, input logic wq, input logic [AW-1:0] ra,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic ack, input logic [DW-1:0] rdat);
      bit            pick_wr;
      logic [AW-1:0] a;
      m_racc = 0; m_wacc = 0; m_rval = 0; m_wval = 0;
      if (!m_out) begin
         if (rq || wq) begin
            pick_wr = (rq && wq) ? !m_last : wq;
            a       = pick_wr ? wa : ra;
            m_out   = 1; m_side = pick_wr; m_age = 0; m_last = pick_wr;
            m_req   = 1; m_we = pick_wr;
            m_addr  = a - (a % LINE_BYTES);
            if (pick_wr) begin
               m_wdata = wd;
               m_wacc  = 1;
            end else begin
               m_racc = 1;
            end
         end
      end else begin
         m_age++;
         if (ack || (m_age == TO)) begin
            m_out = 0; m_req = 0;
            if (m_side) m_wval = 1;
            else begin
               m_rval  = 1;
               m_rdata = ack ? rdat : ZW;
            end
            if (!ack) m_err = 1;
         end
      end
   endtask

   initial begin
      int            n;
      logic          c_rq, c_wq, c_ack;
      logic [AW-1:0] c_ra, c_wa;
      logic [DW-1:0] c_wd, c_rdat;

      //          rq   wq   ra          wa        wd    ack   rdat   racc wacc rval wval req  we   busy addr        wdata rdata
      vecs[0]  = '{1'b1,1'b0,64'h1234,  64'h0,    ZW,   1'b0, ZW,    1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,64'h1220, ZW,   ZW};
      vecs[1]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b0, ZW,    1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,64'h1220, ZW,   ZW};
      vecs[2]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b0, ZW,    1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,64'h1220, ZW,   ZW};
      vecs[3]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b1, A5,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h1220, ZW,   A5};
      vecs[4]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b0, ZW,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h1220, ZW,   A5};
      vecs[5]  = '{1'b0,1'b1,64'h0,     64'h40,   DB,   1'b0, ZW,    1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,64'h40,   DB,   A5};
      vecs[6]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b1, JUNK,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,64'h40,   DB,   A5};
      vecs[7]  = '{1'b1,1'b0,64'h1FFF,  64'h0,    ZW,   1'b0, ZW,    1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,64'h1FE0, DB,   A5};
      vecs[8]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b1, RX,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h1FE0, DB,   RX};
      vecs[9]  = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b0, ZW,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h1FE0, DB,   RX};
      vecs[10] = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b1, JUNK,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'h1FE0, DB,   RX};
      vecs[11] = '{1'b1,1'b0,64'h20,    64'h0,    ZW,   1'b1, JUNK,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,64'h20,   DB,   RX};
      vecs[12] = '{1'b0,1'b0,64'h0,     64'h0,    ZW,   1'b1, R7,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,64'h20,   DB,   R7};

      // Reset values
      step();
      chk("rst_mem_req", DW'(mem_req), ZW);
      chk("rst_busy", DW'(busy), ZW);
      chk("rst_timeout_err", DW'(timeout_err), ZW);
      chk("rst_rd_valid", DW'(rd_valid), ZW);
      chk("rst_wr_acc", DW'(wr_cmd_accepted), ZW);
      chk("rst_mem_addr", DW'(mem_addr), ZW);
      chk("rst_rd_data", rd_data, ZW);
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 13; i++) begin
         rd_req = vecs[i].rq; wr_req = vecs[i].wq; rd_addr = vecs[i].ra; wr_addr = vecs[i].wa;
         wr_data = vecs[i].wd; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdat;
         step();
         chk($sformatf("vec%0d_rd_acc", i), DW'(rd_cmd_accepted), DW'(vecs[i].e_racc));
         chk($sformatf("vec%0d_wr_acc", i), DW'(wr_cmd_accepted), DW'(vecs[i].e_wacc));
         chk($sformatf("vec%0d_rd_valid", i), DW'(rd_valid), DW'(vecs[i].e_rval));
         chk($sformatf("vec%0d_wr_valid", i), DW'(wr_valid), DW'(vecs[i].e_wval));
         chk($sformatf("vec%0d_mem_req", i), DW'(mem_req), DW'(vecs[i].e_req));
         chk($sformatf("vec%0d_mem_we", i), DW'(mem_we), DW'(vecs[i].e_we));
         chk($sformatf("vec%0d_busy", i), DW'(busy), DW'(vecs[i].e_busy));
         chk($sformatf("vec%0d_mem_addr", i), DW'(mem_addr), DW'(vecs[i].e_addr));
         chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rdata);
      end
      clear_inputs();

      // Contention: grants alternate R,W,R,W from reset, loser keeps requesting
      reset_dut();
      for (int r = 0; r < 4; r++) begin
         rd_req = 1'b1; wr_req = 1'b1;
         step();
         chk($sformatf("cont%0d_rd_acc", r), DW'(rd_cmd_accepted), DW'((r % 2) == 0));
         chk($sformatf("cont%0d_wr_acc", r), DW'(wr_cmd_accepted), DW'((r % 2) == 1));
         chk($sformatf("cont%0d_mem_we", r), DW'(mem_we), DW'((r % 2) == 1));
         if ((r % 2) == 0) rd_req = 1'b0;
         else              wr_req = 1'b0;
         mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
         chk($sformatf("cont%0d_rd_valid", r), DW'(rd_valid), DW'((r % 2) == 0));
         chk($sformatf("cont%0d_wr_valid", r), DW'(wr_valid), DW'((r % 2) == 1));
      end
      clear_inputs();

      // Watchdog: good read, then a read that is never acked
      reset_dut();
      rd_req = 1'b1; rd_addr = 64'h80;
      step();
      rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = A5;
      step();
      mem_ack = 1'b0;
      chk("to_pre_rd_data", rd_data, A5);
      rd_req = 1'b1; rd_addr = 64'h100;
      step();
      chk("to_rd_acc", DW'(rd_cmd_accepted), DW'(1'b1));
      rd_req = 1'b0;
      n = 1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (mem_req) n++;
         else break;
      end
      chk("to_req_cycles", DW'(n), DW'(TO));
      chk("to_rd_valid", DW'(rd_valid), DW'(1'b1));
      chk("to_rd_data_zero", rd_data, ZW);
      chk("to_err_set", DW'(timeout_err), DW'(1'b1));
      step();
      chk("to_rd_valid_one", DW'(rd_valid), ZW);
      wr_req = 1'b1; wr_addr = 64'h200; wr_data = DB;
      step();
      wr_req = 1'b0; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("to_wr_valid", DW'(wr_valid), DW'(1'b1));
      chk("to_err_sticky", DW'(timeout_err), DW'(1'b1));
      chk("to_rd_data_kept", rd_data, ZW);

      // Async reset in the middle of a write
      wr_req = 1'b1; wr_addr = 64'h300; wr_data = DB;
      step();
      wr_req = 1'b0;
      step();
      chk("ar_busy_pre", DW'(busy), DW'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("ar_mem_req", DW'(mem_req), ZW);
      chk("ar_busy", DW'(busy), ZW);
      chk("ar_err_clear", DW'(timeout_err), ZW);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("ar_wr_valid%0d", k), DW'(wr_valid), ZW);
      end
      rst = 1'b0;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("ar_late_ack_wr", DW'(wr_valid), ZW);
      chk("ar_late_ack_rd", DW'(rd_valid), ZW);
      rd_req = 1'b1; rd_addr = 64'h3E5;
      step();
      rd_req = 1'b0;
      chk("ar_rd_acc", DW'(rd_cmd_accepted), DW'(1'b1));
      chk("ar_rd_addr", DW'(mem_addr), DW'(64'h3E0));
      step();
      mem_ack = 1'b1; mem_rdata = RX;
      step();
      mem_ack = 1'b0;
      chk("ar_rd_valid", DW'(rd_valid), DW'(1'b1));
      chk("ar_rd_data", rd_data, RX);
      clear_inputs();

      // Random traffic against the reference model
      reset_dut();
      model_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         c_rq  = ($urandom_range(0, 1) == 1);
         c_wq  = ($urandom_range(0, 1) == 1);
         c_ra  = {$urandom, $urandom};
         c_wa  = {$urandom, $urandom};
         c_wd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         c_ack = ($urandom_range(0, 3) == 0);
         c_rdat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rd_req = c_rq; wr_req = c_wq; rd_addr = c_ra; wr_addr = c_wa; wr_data = c_wd;
         mem_ack = c_ack; mem_rdata = c_rdat;
         step();
         model_edge(c_rq, c_wq, c_ra, c_wa, c_wd, c_ack, c_rdat);
         chk("rnd_rd_acc", DW'(rd_cmd_accepted), DW'(m_racc));
         chk("rnd_wr_acc", DW'(wr_cmd_accepted), DW'(m_wacc));
         chk("rnd_rd_valid", DW'(rd_valid), DW'(m_rval));
         chk("rnd_wr_valid", DW'(wr_valid), DW'(m_wval));
         chk("rnd_mem_req", DW'(mem_req), DW'(m_req));
         chk("rnd_mem_we", DW'(mem_we), DW'(m_we));
         chk("rnd_mem_addr", DW'(mem_addr), DW'(m_addr));
         chk("rnd_mem_wdata", mem_wdata, m_wdata);
         chk("rnd_rd_data", rd_data, m_rdata);
         chk("rnd_busy", DW'(busy), DW'(m_out));
         chk("rnd_timeout_err", DW'(timeout_err), DW'(m_err));
      end
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
